// File: rtl/sync_fifo_flags_if.sv
// Handshake/bus bundle for sync_fifo_flags.
//
// Purpose: groups the producer/consumer request lines and the FIFO status/data
// outputs so the FIFO and its user connect through one port.
//
// Ports (signals):
//   w_en, data_in   producer write request and data
//   r_en            consumer pop request
//   clr_err         synchronous clear of the sticky error flags
//   data_out        read data
//   full, empty, almost_full, almost_empty, level   status decoded from fill level
//   overflow, underflow                              sticky error flags
//
// Handshake: a write is accepted on a clk edge when w_en=1 and full=0; a pop
// is accepted when r_en=1 and empty=0. full/empty act as the (inverted)
// ready/valid of the two sides. Requests that are not accepted do nothing
// except set the corresponding sticky error flag.
interface sync_fifo_flags_if #(
  parameter int W     = 8,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic          w_en;
  logic [W-1:0]  data_in;
  logic          r_en;
  logic          clr_err;
  logic [W-1:0]  data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;

  // User side (producer/consumer).
  modport master (
    output w_en, data_in, r_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  w_en, data_in, r_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a registered or first-word-fall-through
// read port. DEPTH may be any integer >= 2 (pointers wrap explicitly).
//
// Ports:
//   clk   clock, all state changes on posedge
//   rstn  asynchronous active-low reset
//   bus   sync_fifo_flags_if.slave -- write/pop requests, clr_err, data_out
//         and all status flags (see the interface file for the handshake)
//
// Parameters:
//   W          data width
//   DEPTH      number of entries (>= 2)
//   AFULL_TH   almost_full when level >= AFULL_TH   (1..DEPTH)
//   AEMPTY_TH  almost_empty when level <= AEMPTY_TH (0..DEPTH-1)
//   FWFT       0: registered read, 1-cycle latency; 1: head word always shown
module sync_fifo_flags #(
  parameter int W         = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic               clk,
  input  logic               rstn,
  sync_fifo_flags_if.slave   bus
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Parameter sanity checks at elaboration.
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          full_s;
  logic          empty_s;
  logic          wr_acc;
  logic          rd_acc;
  logic [W-1:0]  head_word;

  // All flags come straight from the registered level.
  assign full_s  = (level_q == LW'(DEPTH));
  assign empty_s = (level_q == '0);

  // Acceptance uses this cycle's registered flags: a write while full is
  // rejected even if a pop happens on the same edge.
  assign wr_acc = bus.w_en & ~full_s;
  assign rd_acc = bus.r_en & ~empty_s;

  assign head_word = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      dout_d   = head_word;
    end

    if (wr_acc && !rd_acc) begin
      level_d = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - LW'(1);
    end

    // Setting an error flag wins over clearing it in the same cycle.
    if (bus.w_en && full_s) begin
      overflow_d = 1'b1;
    end else if (bus.clr_err) begin
      overflow_d = 1'b0;
    end
    if (bus.r_en && empty_s) begin
      underflow_d = 1'b1;
    end else if (bus.clr_err) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // In FWFT mode the head entry is shown combinationally from storage, so a
  // word written into an empty FIFO appears as soon as empty falls.
  assign bus.data_out     = (FWFT != 0) ? (empty_s ? '0 : head_word) : dout_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (level_q >= LW'(AFULL_TH));
  assign bus.almost_empty = (level_q <= LW'(AEMPTY_TH));
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int W     = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         w_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         r_en = 1'b0;
  logic         clr_err = 1'b0;

  // Two instances fed identical stimulus: registered read and FWFT.
  sync_fifo_flags_if #(.W(W), .DEPTH(DEPTH)) fa ();
  sync_fifo_flags_if #(.W(W), .DEPTH(DEPTH)) fb ();

  assign fa.w_en = w_en;  assign fa.data_in = data_in;
  assign fa.r_en = r_en;  assign fa.clr_err = clr_err;
  assign fb.w_en = w_en;  assign fb.data_in = data_in;
  assign fb.r_en = r_en;  assign fb.clr_err = clr_err;

  sync_fifo_flags #(.W(W), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0))
    dut_a (.clk(clk), .rstn(rstn), .bus(fa));
  sync_fifo_flags #(.W(W), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1))
    dut_b (.clk(clk), .rstn(rstn), .bus(fb));

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
  logic         exp_ovf;
  logic         exp_unf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  // One clock edge of FIFO behaviour, using the inputs present at that edge.
  task automatic model_edge();
    bit was_full, was_empty;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (r_en && !was_empty) exp_dout = exp_q.pop_front();
    if (w_en && !was_full)  exp_q.push_back(data_in);
    if (w_en && was_full)   exp_ovf = 1'b1;
    else if (clr_err)       exp_ovf = 1'b0;
    if (r_en && was_empty)  exp_unf = 1'b1;
    else if (clr_err)       exp_unf = 1'b0;
  endtask

  task automatic check_all();
    int lvl;
    lvl = exp_q.size();
    check_val("A.level",        32'(fa.level),        lvl);
    check_val("A.full",         32'(fa.full),         32'(lvl == DEPTH));
    check_val("A.empty",        32'(fa.empty),        32'(lvl == 0));
    check_val("A.almost_full",  32'(fa.almost_full),  32'(lvl >= AF));
    check_val("A.almost_empty", 32'(fa.almost_empty), 32'(lvl <= AE));
    check_val("A.overflow",     32'(fa.overflow),     32'(exp_ovf));
    check_val("A.underflow",    32'(fa.underflow),    32'(exp_unf));
    check_val("A.data_out",     32'(fa.data_out),     32'(exp_dout));
    check_val("B.level",        32'(fb.level),        lvl);
    check_val("B.overflow",     32'(fb.overflow),     32'(exp_ovf));
    check_val("B.underflow",    32'(fb.underflow),    32'(exp_unf));
    check_val("B.data_out",     32'(fb.data_out),     (lvl > 0) ? 32'(exp_q[0]) : 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    w_en = w; data_in = d; r_en = r; clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear_flags();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check_all();

    // Fill to full, then one extra write is rejected.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, W'(8'h11 + i), 1'b0, 1'b0);
      check_val("fill.level", 32'(fa.level), i + 1);
    end
    check_val("fill.almost_full_at5", 32'(fa.almost_full), 1);
    cycle(1'b1, 8'h16, 1'b0, 1'b0);
    check_val("fill.overflow", 32'(fa.overflow), 1);
    check_val("fill.level_held", 32'(fa.level), DEPTH);
    clear_flags();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("fill.read_order", 32'(fa.data_out), 32'h11 + i);
    end

    // Wrap: interleaved write/read pairs through the non-power-of-two ring.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, W'(i), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("wrap.order", 32'(fa.data_out), i);
    end

    // Simultaneous read/write at level 3, at full and at empty.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, W'(8'h40 + i), 1'b1, 1'b0);
      check_val("simul.level3", 32'(fa.level), 3);
    end
    cycle(1'b1, 8'h50, 1'b0, 1'b0);
    cycle(1'b1, 8'h51, 1'b0, 1'b0);
    cycle(1'b1, 8'h52, 1'b1, 1'b0);
    check_val("simul.full_level", 32'(fa.level), DEPTH - 1);
    check_val("simul.full_ovf", 32'(fa.overflow), 1);
    clear_flags();
    drain();
    cycle(1'b1, 8'h53, 1'b1, 1'b0);
    check_val("simul.empty_level", 32'(fa.level), 1);
    check_val("simul.empty_unf", 32'(fa.underflow), 1);
    clear_flags();
    drain();

    // FWFT vs registered read of a single word.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check_val("fwft.show", 32'(fb.data_out), 32'hA5);
    check_val("fwft.empty", 32'(fb.empty), 0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("fwft.pop_empty", 32'(fb.empty), 1);
    check_val("fwft.pop_dout", 32'(fb.data_out), 0);
    check_val("reg.read_dout", 32'(fa.data_out), 32'hA5);

    // Sticky underflow and clear priority.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("err.unf_set", 32'(fa.underflow), 1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check_val("err.unf_set_beats_clr", 32'(fa.underflow), 1);
    idle();
    check_val("err.unf_sticky", 32'(fa.underflow), 1);
    clear_flags();
    check_val("err.unf_cleared", 32'(fa.underflow), 0);

    // Random traffic: write-heavy phase, then read-heavy phase.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      cycle(logic'($urandom_range(0, 99) < wp), W'($urandom_range(0, 255)),
            logic'($urandom_range(0, 99) < 100 - wp), logic'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a burst at level 3.
    clear_flags();
    drain();
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 8'h63, 1'b0, 1'b0);
    w_en = 1'b1; data_in = 8'h64;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("rst.level_async", 32'(fa.level), 0);
    @(posedge clk); #1;
    check_all();
    w_en = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check_all();
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("rst.after_release", 32'(fa.data_out), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
